// File: rtl/spi_arbiter.sv
// Shares one SPI core among NUM_REQ requesters: grants one session at a time and
// routes the granted requester's chip selects, data and handshakes to the core.
module spi_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int NUM_CS      = 2,
   parameter int GAP_CYCLES  = 1,
   parameter int ROUND_ROBIN = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   output logic [NUM_REQ-1:0]        grant,
   input  logic [NUM_REQ*8-1:0]      req_data_tx,
   input  logic [NUM_REQ-1:0]        req_txn_start,
   input  logic [NUM_REQ-1:0]        req_force_clock,
   input  logic [NUM_REQ*NUM_CS-1:0] req_ce_n,
   output logic [7:0]                req_data_rx,
   output logic [NUM_REQ-1:0]        req_txn_done,
   output logic [7:0]                spi_data_tx,
   output logic                      spi_txn_start,
   output logic                      spi_force_clock,
   input  logic [7:0]                spi_data_rx,
   input  logic                      spi_txn_done,
   output logic [NUM_CS-1:0]         spi_ce_n
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_BUSY    = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [NUM_REQ-1:0] grant_r;
   logic [IDX_W-1:0]   gidx_r;
   logic [IDX_W-1:0]   last_winner_r;
   logic [IDX_W-1:0]   winner_s;
   logic [IDX_W-1:0]   cand_s;
   logic               win_found_s;
   logic [3:0]         gap_cnt_r;

   assign grant = grant_r;

   // Winner selection; the lowest candidate reached in the search is assigned last and wins
   always_comb begin
      winner_s    = last_winner_r;
      cand_s      = last_winner_r;
      win_found_s = 1'b0;
      if (ROUND_ROBIN != 0) begin
         for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s      = IDX_W'((int'(last_winner_r) + k) % NUM_REQ);
            winner_s    = req[cand_s] ? cand_s : winner_s;
            win_found_s = win_found_s | req[cand_s];
         end
      end else begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s      = IDX_W'(i);
            winner_s    = req[cand_s] ? cand_s : winner_s;
            win_found_s = win_found_s | req[cand_s];
         end
      end
   end

   // State register plus grant, last winner and gap counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         grant_r       <= '0;
         gidx_r        <= '0;
         last_winner_r <= IDX_W'(NUM_REQ - 1);
         gap_cnt_r     <= 4'd0;
      end else begin
         state_r <= state_s;
         if (state_r == ST_IDLE && win_found_s) begin
            grant_r       <= ONE_HOT0 << winner_s;
            gidx_r        <= winner_s;
            last_winner_r <= winner_s;
         end else if (state_s == ST_GAP && state_r != ST_GAP) begin
            grant_r   <= '0;
            gap_cnt_r <= 4'(GAP_CYCLES - 1);
         end else if (state_r == ST_GAP && gap_cnt_r != 4'd0) begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
         end else begin
            gap_cnt_r <= gap_cnt_r;
         end
      end
   end

   // Next-state logic; a start in GRANTED wins over a simultaneous req drop
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:    state_s = win_found_s ? ST_GRANTED : ST_IDLE;
         ST_GRANTED: begin
            if (req_txn_start[gidx_r]) begin
               state_s = ST_BUSY;
            end else if (!req[gidx_r]) begin
               state_s = ST_GAP;
            end else begin
               state_s = ST_GRANTED;
            end
         end
         ST_BUSY: begin
            if (spi_txn_done) begin
               state_s = req[gidx_r] ? ST_GRANTED : ST_GAP;
            end else begin
               state_s = ST_BUSY;
            end
         end
         ST_GAP:     state_s = (gap_cnt_r == 4'd0) ? ST_IDLE : ST_GAP;
         default:    state_s = ST_IDLE;
      endcase
   end

   // Output routing from the granted requester while a session is open
   always_comb begin
      spi_ce_n        = '1;
      spi_data_tx     = 8'h00;
      spi_force_clock = 1'b0;
      spi_txn_start   = 1'b0;
      req_txn_done    = '0;
      req_data_rx     = 8'h00;
      if (state_r == ST_GRANTED || state_r == ST_BUSY) begin
         spi_ce_n             = req_ce_n[int'(gidx_r) * NUM_CS +: NUM_CS];
         spi_data_tx          = req_data_tx[int'(gidx_r) * 8 +: 8];
         spi_force_clock      = req_force_clock[gidx_r];
         req_data_rx          = spi_data_rx;
         spi_txn_start        = (state_r == ST_GRANTED) ? req_txn_start[gidx_r] : 1'b0;
         req_txn_done[gidx_r] = (state_r == ST_BUSY) ? spi_txn_done : 1'b0;
      end else begin
         spi_ce_n = '1;
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench: directed stimulus queues expected grants and done/rx events,
// monitors pop and compare on every new grant or done pulse.
module tb_spi_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // instance A: defaults (2 requesters, 2 chip selects)
   logic [1:0]  req_a = '0, start_a = '0, grant_a, done_out_a;
   logic [1:0]  force_a = 2'b01;
   logic [15:0] tx_a = 16'h5AA5;
   logic [3:0]  ce_a = 4'b0110;
   logic [7:0]  rx_out_a, spi_tx_a, spi_rx_a = 8'h00;
   logic        spi_start_a, spi_force_a, spi_done_a = 1'b0;
   logic [1:0]  spi_ce_a;

   // instances B (round robin) and C (fixed priority): 4 requesters, 1 chip select
   logic [3:0]  req_b = '0, req_c = '0, start_bc = '0, grant_b, grant_c, done_out_b, done_out_c;
   logic        done_bc = 1'b0;
   logic [7:0]  rx_out_b, rx_out_c, tx_out_b, tx_out_c;
   logic        st_b, st_c, fc_b, fc_c;
   logic [0:0]  ce_out_b, ce_out_c;

   spi_arbiter u_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .grant(grant_a), .req_data_tx(tx_a),
      .req_txn_start(start_a), .req_force_clock(force_a), .req_ce_n(ce_a),
      .req_data_rx(rx_out_a), .req_txn_done(done_out_a), .spi_data_tx(spi_tx_a),
      .spi_txn_start(spi_start_a), .spi_force_clock(spi_force_a), .spi_data_rx(spi_rx_a),
      .spi_txn_done(spi_done_a), .spi_ce_n(spi_ce_a));

   spi_arbiter #(.NUM_REQ(4), .NUM_CS(1), .GAP_CYCLES(1), .ROUND_ROBIN(1)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .grant(grant_b), .req_data_tx(32'h44332211),
      .req_txn_start(start_bc), .req_force_clock(4'b0000), .req_ce_n(4'b0000),
      .req_data_rx(rx_out_b), .req_txn_done(done_out_b), .spi_data_tx(tx_out_b),
      .spi_txn_start(st_b), .spi_force_clock(fc_b), .spi_data_rx(8'h11),
      .spi_txn_done(done_bc), .spi_ce_n(ce_out_b));

   spi_arbiter #(.NUM_REQ(4), .NUM_CS(1), .GAP_CYCLES(1), .ROUND_ROBIN(0)) u_c (
      .clk(clk), .rst_n(rst_n), .req(req_c), .grant(grant_c), .req_data_tx(32'h44332211),
      .req_txn_start(start_bc), .req_force_clock(4'b0000), .req_ce_n(4'b0000),
      .req_data_rx(rx_out_c), .req_txn_done(done_out_c), .spi_data_tx(tx_out_c),
      .spi_txn_start(st_c), .spi_force_clock(fc_c), .spi_data_rx(8'h22),
      .spi_txn_done(done_bc), .spi_ce_n(ce_out_c));

   logic [31:0] q_ga[$], q_da[$], q_gb[$], q_gc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every new nonzero grant and every done pulse consumes one expected entry
   initial begin
      logic [1:0] prev_a;
      logic [3:0] prev_b, prev_c;
      logic [31:0] e;
      prev_a = '0; prev_b = '0; prev_c = '0;
      forever begin
         @(negedge clk);
         if (grant_a != prev_a && grant_a != 2'b00) begin
            e = (q_ga.size() != 0) ? q_ga.pop_front() : 32'hFFFF_FFFF;
            check("grant_a", 32'(grant_a), e);
         end
         if (done_out_a != 2'b00) begin
            e = (q_da.size() != 0) ? q_da.pop_front() : 32'hFFFF_FFFF;
            check("done_rx_a", 32'({done_out_a, rx_out_a}), e);
         end
         if (grant_b != prev_b && grant_b != 4'b0000) begin
            e = (q_gb.size() != 0) ? q_gb.pop_front() : 32'hFFFF_FFFF;
            check("grant_rr", 32'(grant_b), e);
         end
         if (grant_c != prev_c && grant_c != 4'b0000) begin
            e = (q_gc.size() != 0) ? q_gc.pop_front() : 32'hFFFF_FFFF;
            check("grant_fp", 32'(grant_c), e);
         end
         prev_a = grant_a; prev_b = grant_b; prev_c = grant_c;
      end
   end

   // One single-byte session on B (sel=0) or C (sel=1), ending with a one-cycle req drop
   task automatic session(input bit sel);
      logic [3:0] g;
      bit got;
      g = 4'b0000;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         g = sel ? grant_c : grant_b;
         got = (g != 4'b0000);
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL %s_grant_wait: got no grant within 10 cycles", sel ? "fp" : "rr");
      end
      start_bc = 4'hF; tick(); start_bc = 4'h0;
      done_bc = 1'b1;  tick(); done_bc = 1'b0;
      if (sel) req_c = ~g; else req_b = ~g;
      tick();
      if (sel) req_c = 4'hF; else req_b = 4'hF;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check("rst_grant", 32'(grant_a), 32'h0);
      check("rst_ce", 32'(spi_ce_a), 32'h3);
      check("rst_start_force", 32'({spi_start_a, spi_force_a}), 32'h0);
      check("rst_done", 32'(done_out_a), 32'h0);
      tick(); tick();
      rst_n = 1'b1;

      // both request: requester 0 wins first
      q_ga.push_back(32'h1);
      req_a = 2'b11;
      check("grant_before_edge", 32'(grant_a), 32'h0);
      tick();
      check("grant01", 32'(grant_a), 32'h1);
      check("ce_req0", 32'(spi_ce_a), 32'h2);
      check("tx_req0", 32'(spi_tx_a), 32'hA5);
      check("force_req0", 32'(spi_force_a), 32'h1);

      // start from the non-granted requester is ignored
      start_a = 2'b10; #1;
      check("start_nongranted", 32'(spi_start_a), 32'h0);
      tick();
      start_a = 2'b01; #1;
      check("start_granted", 32'(spi_start_a), 32'h1);
      tick();
      #1;
      check("start_in_busy", 32'(spi_start_a), 32'h0);
      start_a = 2'b00;
      q_da.push_back(32'({2'b01, 8'h3C}));
      spi_rx_a = 8'h3C; spi_done_a = 1'b1;
      tick();
      spi_done_a = 1'b0;

      // spurious done while GRANTED: no done pulse, state stays GRANTED
      spi_done_a = 1'b1; #1;
      check("spurious_done_granted", 32'(done_out_a), 32'h0);
      tick();
      spi_done_a = 1'b0;
      start_a = 2'b01; #1;
      check("still_granted", 32'(spi_start_a), 32'h1);
      tick();
      start_a = 2'b00;

      // requester 0 drops req mid-transfer: CE held until done
      req_a = 2'b10;
      tick(); tick();
      check("ce_held_busy", 32'(spi_ce_a), 32'h2);
      check("grant_held_busy", 32'(grant_a), 32'h1);
      q_da.push_back(32'({2'b01, 8'h77}));
      spi_rx_a = 8'h77; spi_done_a = 1'b1;
      tick();
      spi_done_a = 1'b0;
      check("gap_ce", 32'(spi_ce_a), 32'h3);
      check("gap_grant", 32'(grant_a), 32'h0);
      check("gap_rx_zero", 32'(rx_out_a), 32'h0);
      q_ga.push_back(32'h2);
      tick();
      check("idle_ce", 32'(spi_ce_a), 32'h3);
      check("idle_grant", 32'(grant_a), 32'h0);
      tick();
      check("grant10", 32'(grant_a), 32'h2);
      check("ce_req1", 32'(spi_ce_a), 32'h1);
      check("tx_req1", 32'(spi_tx_a), 32'h5A);
      check("force_req1", 32'(spi_force_a), 32'h0);

      // reset while BUSY drops CE at once; a later done is ignored
      start_a = 2'b10;
      tick();
      start_a = 2'b00;
      check("busy_ce_req1", 32'(spi_ce_a), 32'h1);
      rst_n = 1'b0; req_a = 2'b00; #1;
      check("async_rst_ce", 32'(spi_ce_a), 32'h3);
      check("async_rst_grant", 32'(grant_a), 32'h0);
      tick();
      rst_n = 1'b1;
      spi_done_a = 1'b1; #1;
      check("post_rst_done", 32'(done_out_a), 32'h0);
      tick();
      spi_done_a = 1'b0;
      check("post_rst_grant", 32'(grant_a), 32'h0);

      // round robin, all four requesting
      q_gb.push_back(32'h1); q_gb.push_back(32'h2); q_gb.push_back(32'h4);
      q_gb.push_back(32'h8); q_gb.push_back(32'h1);
      req_b = 4'hF;
      for (int s = 0; s < 5; s++) session(1'b0);
      req_b = 4'h0;
      tick(); tick();

      // fixed priority, same stimulus: requester 0 every time
      for (int s = 0; s < 5; s++) q_gc.push_back(32'h1);
      req_c = 4'hF;
      for (int s = 0; s < 5; s++) session(1'b1);
      req_c = 4'h0;
      tick(); tick(); tick();

      check("q_grant_a_left", 32'(q_ga.size()), 32'h0);
      check("q_done_a_left", 32'(q_da.size()), 32'h0);
      check("q_rr_left", 32'(q_gb.size()), 32'h0);
      check("q_fp_left", 32'(q_gc.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
